// File: rtl/life_pkg.sv
// Shared types and defaults for the Game-of-Life engine.
// Holds the FSM state encoding, the default B3/S23 rule masks,
// the generation counter width and the per-cell rule helper.
package life_pkg;

    localparam int GEN_W = 16;

    // Conway's rule: born with 3 neighbours, survives with 2 or 3
    localparam logic [8:0] B3_MASK  = 9'b000001000;
    localparam logic [8:0] S23_MASK = 9'b000001100;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        SWAP
    } state_t;

    // Next state of one cell given its state and live-neighbour count (0..8)
    function automatic logic apply_rule(input logic       alive,
                                        input logic [3:0] n,
                                        input logic [8:0] birth,
                                        input logic [8:0] survive);
        return alive ? survive[n] : birth[n];
    endfunction

endpackage

// File: rtl/life_row_next.sv
// Combinational next-generation of one grid row.
// Takes the row above, the row itself and the row below and returns
// the row's next state. With TORUS set the columns wrap around,
// otherwise cells beyond either edge count as dead.
module life_row_next
    import life_pkg::*;
#(
    parameter int         COLS         = 16,
    parameter logic [8:0] BIRTH_MASK   = B3_MASK,
    parameter logic [8:0] SURVIVE_MASK = S23_MASK,
    parameter bit         TORUS        = 1'b0
) (
    input  logic [COLS-1:0] above,
    input  logic [COLS-1:0] cur,
    input  logic [COLS-1:0] below,
    output logic [COLS-1:0] next
);

    // Bit c+1 of each padded row is column c; bits 0 and COLS+1 are the
    // out-of-grid columns -1 and COLS.
    logic [COLS+1:0] pad_a;
    logic [COLS+1:0] pad_c;
    logic [COLS+1:0] pad_b;

    // Pad each row with one column either side: wrapped cells or dead cells
    always_comb begin
        pad_a = {(TORUS ? above[0] : 1'b0), above, (TORUS ? above[COLS-1] : 1'b0)};
        pad_c = {(TORUS ? cur[0]   : 1'b0), cur,   (TORUS ? cur[COLS-1]   : 1'b0)};
        pad_b = {(TORUS ? below[0] : 1'b0), below, (TORUS ? below[COLS-1] : 1'b0)};
    end

    // Count the eight neighbours of every column and apply the rule masks
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch can be inferred.
        next = '0;
        for (int c = 0; c < COLS; c++) begin
            logic [3:0] n;
            n = 4'(pad_a[c]) + 4'(pad_a[c+1]) + 4'(pad_a[c+2])
              + 4'(pad_c[c])                  + 4'(pad_c[c+2])
              + 4'(pad_b[c]) + 4'(pad_b[c+1]) + 4'(pad_b[c+2]);
            next[c] = apply_rule(cur[c], n, BIRTH_MASK, SURVIVE_MASK);
        end
    end

endmodule

// File: rtl/life_engine.sv
// Game-of-Life generation engine with double-buffered cell storage.
// The front bank is displayed and seeded; the back bank is filled one
// row per clock while a generation is computed, then the banks swap.
// Define LIFE_TORUS_EN for a toroidal grid; otherwise the border is dead.
module life_engine
    import life_pkg::*;
#(
    parameter int         COLS           = 16,
    parameter int         ROWS           = 16,
    parameter int         FRAMES_PER_GEN = 60,
    parameter logic [8:0] BIRTH_MASK     = B3_MASK,
    parameter logic [8:0] SURVIVE_MASK   = S23_MASK,
    localparam int        X_W            = $clog2(COLS),
    localparam int        Y_W            = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_tick,
    input  logic             run,
    input  logic             step,
    input  logic             wr_en,
    output logic             wr_ready,
    input  logic [X_W-1:0]   wr_x,
    input  logic [Y_W-1:0]   wr_y,
    input  logic             wr_data,
    input  logic [X_W-1:0]   rd_x,
    input  logic [Y_W-1:0]   rd_y,
    output logic             rd_cell,
    output logic             busy,
    output logic             gen_done,
    output logic [GEN_W-1:0] gen_count
);

`ifdef LIFE_TORUS_EN
    localparam bit TORUS = 1'b1;
`else
    localparam bit TORUS = 1'b0;
`endif

    localparam logic [X_W:0]   COLS_L     = (X_W+1)'(COLS);
    localparam logic [Y_W:0]   ROWS_L     = (Y_W+1)'(ROWS);
    localparam logic [Y_W-1:0] LAST_ROW   = Y_W'(ROWS - 1);
    localparam logic [7:0]     LAST_FRAME = 8'(FRAMES_PER_GEN - 1);

    logic [COLS-1:0] bank0 [ROWS];
    logic [COLS-1:0] bank1 [ROWS];
    logic            bank_sel;      // 0: bank0 is front, 1: bank1 is front

    state_t          state;
    logic [Y_W-1:0]  row_cnt;
    logic [7:0]      frame_cnt;

    logic [COLS-1:0] row_above;
    logic [COLS-1:0] row_cur;
    logic [COLS-1:0] row_below;
    logic [COLS-1:0] row_next;

    logic            frame_term;
    logic            trigger;
    logic            wr_hit;
    logic            rd_ok;

    assign frame_term = frame_tick && run && (frame_cnt == LAST_FRAME);
    assign trigger    = (state == IDLE) && (frame_term || (!run && step));
    assign wr_hit     = wr_en && wr_ready
                     && ({1'b0, wr_x} < COLS_L) && ({1'b0, wr_y} < ROWS_L);
    assign rd_ok      = ({1'b0, rd_x} < COLS_L) && ({1'b0, rd_y} < ROWS_L);

    // Fetch the front-bank rows around row_cnt, substituting wrapped or dead rows at the edges
    always_comb begin
        row_above = '0;
        row_below = '0;
        row_cur   = bank_sel ? bank1[row_cnt] : bank0[row_cnt];
        if (row_cnt != '0) begin
            row_above = bank_sel ? bank1[row_cnt - 1'b1] : bank0[row_cnt - 1'b1];
        end else if (TORUS) begin
            row_above = bank_sel ? bank1[LAST_ROW] : bank0[LAST_ROW];
        end
        if (row_cnt != LAST_ROW) begin
            row_below = bank_sel ? bank1[row_cnt + 1'b1] : bank0[row_cnt + 1'b1];
        end else if (TORUS) begin
            row_below = bank_sel ? bank1[0] : bank0[0];
        end
    end

    life_row_next #(
        .COLS         (COLS),
        .BIRTH_MASK   (BIRTH_MASK),
        .SURVIVE_MASK (SURVIVE_MASK),
        .TORUS        (TORUS)
    ) u_row_next (
        .above (row_above),
        .cur   (row_cur),
        .below (row_below),
        .next  (row_next)
    );

    // Cell storage: seed writes land in the front bank, computed rows in the back bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the banks are cleared on reset because the grid must come up empty; this keeps them in flops.
            for (int r = 0; r < ROWS; r++) begin
                bank0[r] <= '0;
                bank1[r] <= '0;
            end
        end else begin
            if (wr_hit) begin
                if (bank_sel) bank1[wr_y][wr_x] <= wr_data;
                else          bank0[wr_y][wr_x] <= wr_data;
            end
            if (state == COMPUTE) begin
                if (bank_sel) bank0[row_cnt] <= row_next;
                else          bank1[row_cnt] <= row_next;
            end
        end
    end

    // Frame divider: counts frame ticks while running, held at zero when stopped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (!run) begin
            frame_cnt <= '0;
        end else if (frame_tick) begin
            frame_cnt <= (frame_cnt == LAST_FRAME) ? 8'd0 : frame_cnt + 8'd1;
        end
    end

    // Generation sequencer with registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
            state     <= IDLE;
            row_cnt   <= '0;
            bank_sel  <= 1'b0;
            gen_count <= '0;
            gen_done  <= 1'b0;
            busy      <= 1'b0;
            wr_ready  <= 1'b1;
        end else begin
            gen_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state    <= COMPUTE;
                        row_cnt  <= '0;
                        busy     <= 1'b1;
                        wr_ready <= 1'b0;
                    end
                end
                COMPUTE: begin
                    if (row_cnt == LAST_ROW) begin
                        state    <= SWAP;
                        gen_done <= 1'b1;
                    end else begin
                        row_cnt <= row_cnt + 1'b1;
                    end
                end
                SWAP: begin
                    state     <= IDLE;
                    bank_sel  <= ~bank_sel;
                    gen_count <= gen_count + 1'b1;
                    busy      <= 1'b0;
                    wr_ready  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Registered read port on the front bank; out-of-range coordinates read as dead
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cell <= 1'b0;
        end else if (rd_ok) begin
            rd_cell <= bank_sel ? bank1[rd_y][rd_x] : bank0[rd_y][rd_x];
        end else begin
            rd_cell <= 1'b0;
        end
    end

endmodule
